a_send_fsm: RTL

- Transmit-side controller for the mux-recirculation multi-cycle-path (MCP) CDC handshake. It runs in the source (a) clock domain and accepts words from a local valid/ready stream.
- It holds each word stable on adata and issues a toggle-type enable across to the b-domain receive FSM.
- It synchronizes the b-domain acknowledge toggle back into aclk and re-opens for the next word only after that acknowledge arrives.
- Only one word is in flight at a time.

---
 rtl/a_send_fsm.sv | 137 +++++++++++++
 1 files changed

// File: rtl/a_send_fsm.sv
// Source-domain send controller for the mux-recirculation MCP CDC handshake.
// Optional BUSY watchdog enabled by defining A_SEND_TIMEOUT_EN.
module a_send_fsm #(
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic          aclk,
    input  logic          arst,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic [DW-1:0] adata,
    output logic          a_en_tgl,
    input  logic          b_ack_tgl,
    output logic          aack,
    output logic          proto_err,
    output logic          a_timeout
);

    typedef enum logic [0:0] {StReady, StBusy} state_e;

    state_e                 state_q, state_d;
    logic [DW-1:0]          adata_q, adata_d;
    logic                   en_q, en_d;
    logic                   perr_q, perr_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_prev_q;
    logic                   aack_q;
    logic                   ack_edge;
    logic                   accept;

    assign ack_edge = sync_q[SYNC_STAGES-1] ^ ack_prev_q;

    // Ack toggle synchronizer and edge detector; aack is registered from the edge.
    always_ff @(posedge aclk) begin
        if (arst) begin
            sync_q     <= '0;
            ack_prev_q <= 1'b0;
            aack_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], b_ack_tgl};
            ack_prev_q <= sync_q[SYNC_STAGES-1];
            aack_q     <= ack_edge;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q <= StReady;
            adata_q <= '0;
            en_q    <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adata_q <= adata_d;
            en_q    <= en_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adata_d = adata_q;
        en_d    = en_q;
        perr_d  = perr_q;
        accept  = 1'b0;
        unique case (state_q)
            StReady: begin
                if (s_valid) begin
                    accept  = 1'b1;
                    adata_d = s_data;
                    en_d    = ~en_q;
                    state_d = StBusy;
                end
                if (aack_q) begin
                    perr_d = 1'b1;
                end
            end
            StBusy: begin
                if (aack_q) begin
                    state_d = StReady;
                end
            end
        endcase
    end

    assign s_ready   = (state_q == StReady);
    assign adata     = adata_q;
    assign a_en_tgl  = en_q;
    assign aack      = aack_q;
    assign proto_err = perr_q;

`ifdef A_SEND_TIMEOUT_EN
    localparam int unsigned     CntW   = $clog2(TIMEOUT_CYC);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tmo_q, tmo_d;

    // Counter saturates at CntMax; the transfer itself is never aborted.
    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == StBusy) begin
            if (cnt_q == CntMax) begin
                tmo_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign a_timeout = tmo_q;
`else
    assign a_timeout = 1'b0;
`endif

`ifndef SYNTHESIS
    a_busy_hold: assert property (@(posedge aclk) disable iff (arst)
        (state_q == StBusy && !aack_q) |=>
            (state_q == StBusy && $stable(adata_q) && $stable(en_q)));
`endif

endmodule
